// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: bundle of the register-file ports between issue/write-back
// and the register file.
//   master : issue/write-back side (drives write, read and reservation requests)
//   slave  : register file (returns read data, stall and busy vector)
interface reg_file_2r1w_if #(
  parameter int SIZE     = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic                wr_en_i;
  logic [ADDR_W-1:0]   wr_addr_i;
  logic [SIZE-1:0]     din_i;
  logic                rd_en_a_i;
  logic                rd_en_b_i;
  logic [ADDR_W-1:0]   rd_addr_a_i;
  logic [ADDR_W-1:0]   rd_addr_b_i;
  logic [SIZE-1:0]     dout_a_o;
  logic [SIZE-1:0]     dout_b_o;
  logic                busy_set_i;
  logic [ADDR_W-1:0]   busy_addr_i;
  logic                stall_o;
  logic [NUM_REGS-1:0] busy_o;

  modport master (
    output wr_en_i, wr_addr_i, din_i,
    output rd_en_a_i, rd_en_b_i, rd_addr_a_i, rd_addr_b_i,
    output busy_set_i, busy_addr_i,
    input  dout_a_o, dout_b_o, stall_o, busy_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, din_i,
    input  rd_en_a_i, rd_en_b_i, rd_addr_a_i, rd_addr_b_i,
    input  busy_set_i, busy_addr_i,
    output dout_a_o, dout_b_o, stall_o, busy_o
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two registered read ports, one write port, hard-wired zero
// register at address 0, write-to-read forwarding and a per-register busy
// scoreboard that stalls reads of registers still awaiting write-back.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : slave side of reg_file_2r1w_if (write, two reads, reservation,
//             read data, stall, busy vector)
module reg_file_2r1w #(
  parameter int SIZE     = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  reg_file_2r1w_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_REGS-1:1][SIZE-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:1]           busy_q, busy_d;
  logic [SIZE-1:0]               dout_a_q, dout_a_d;
  logic [SIZE-1:0]               dout_b_q, dout_b_d;

  // Full address-space views: address 0 and unimplemented addresses read as
  // zero / not busy, so lookups never need a range compare.
  logic [DEPTH-1:0] valid_map;
  logic [DEPTH-1:0] busy_map;
  logic [SIZE-1:0]  regs_map [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_map
    if (g > 0 && g < NUM_REGS) begin : g_real
      assign valid_map[g] = 1'b1;
      assign busy_map[g]  = busy_q[g];
      assign regs_map[g]  = regs_q[g];
    end else begin : g_zero
      assign valid_map[g] = 1'b0;
      assign busy_map[g]  = 1'b0;
      assign regs_map[g]  = '0;
    end
  end

  logic            fwd_a, fwd_b, stall;
  logic [SIZE-1:0] val_a, val_b;

  always_comb begin
    fwd_a = bus.wr_en_i && (bus.wr_addr_i == bus.rd_addr_a_i);
    fwd_b = bus.wr_en_i && (bus.wr_addr_i == bus.rd_addr_b_i);
    // A write landing this cycle satisfies the read, so it does not stall.
    stall = (bus.rd_en_a_i && busy_map[bus.rd_addr_a_i] && !fwd_a) ||
            (bus.rd_en_b_i && busy_map[bus.rd_addr_b_i] && !fwd_b);

    val_a = '0;
    if (valid_map[bus.rd_addr_a_i]) val_a = fwd_a ? bus.din_i : regs_map[bus.rd_addr_a_i];
    val_b = '0;
    if (valid_map[bus.rd_addr_b_i]) val_b = fwd_b ? bus.din_i : regs_map[bus.rd_addr_b_i];

    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.wr_en_i && bus.wr_addr_i == ADDR_W'(i)) begin
        regs_d[i] = bus.din_i;
        busy_d[i] = 1'b0;
      end
      // Set after clear: a new producer issued as the old one retires keeps
      // the register reserved.
      if (bus.busy_set_i && bus.busy_addr_i == ADDR_W'(i)) busy_d[i] = 1'b1;
    end

    // Any stall freezes both ports so they stay in lockstep.
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (!stall) begin
      if (bus.rd_en_a_i) dout_a_d = val_a;
      if (bus.rd_en_b_i) dout_b_d = val_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q   <= '0;
      busy_q   <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign bus.dout_a_o = dout_a_q;
  assign bus.dout_b_o = dout_b_q;
  assign bus.stall_o  = stall;
  assign bus.busy_o   = {busy_q, 1'b0};
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Two-read, one-write register file that implements the same contract as the zero register for address 0: writes to it are discarded and reads return zero. Registered read ports with write-to-read forwarding. A per-register busy scoreboard lets the issue stage reserve a destination and stall reads of values not yet written back. Sits between decode/issue (read side, reservations) and write-back (write side) in the datapath.

## Interface
- SIZE, 8, data width in bits
- NUM_REGS, 8, number of architectural registers (address 0 is the zero register)
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS

- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- wr_en_i  in  1  write strobe from write-back
- wr_addr_i  in  ADDR_W  write address
- din_i  in  SIZE  write data
- rd_en_a_i / rd_en_b_i  in  1  read request, port A / B
- rd_addr_a_i / rd_addr_b_i  in  ADDR_W  read address, port A / B
- dout_a_o / dout_b_o  out  SIZE  registered read data, port A / B
- busy_set_i  in  1  reserve a destination register (mark busy)
- busy_addr_i  in  ADDR_W  register to reserve
- stall_o  out  1  combinational; a requested read targets a busy, not-yet-forwarded register
- busy_o  out  NUM_REGS  registered busy vector; bit 0 always 0

## Operation
- Storage: NUM_REGS-1 SIZE-bit registers for addresses 1..NUM_REGS-1. No storage for address 0.
- Write: when wr_en_i=1, and wr_addr_i is nonzero and < NUM_REGS, reg[wr_addr_i] <= din_i and busy[wr_addr_i] <= 0. Writes to address 0 or out of range are discarded with no state change.
- Read: when rd_en_x_i=1 and stall_o=0, dout_x_o <= value(rd_addr_x_i). When rd_en_x_i=0 or stall_o=1, dout_x_o holds.
- value(addr), evaluated in priority order:
  - 0 when addr is 0 or >= NUM_REGS;
  - otherwise din_i when wr_en_i=1 and wr_addr_i == addr (forwarding);
  - otherwise reg[addr].
- Busy set: busy_set_i=1 with nonzero, in-range busy_addr_i sets busy[busy_addr_i]. Address 0 or out of range is ignored.
- Simultaneous set and write to the same address: set wins, so busy stays 1 and the data is still written. This is the case of a new producer issued as the old one retires.
- stall_o = (rd_en_a_i & busy[rd_addr_a_i] & !fwd_a) | (rd_en_b_i & busy[rd_addr_b_i] & !fwd_b).
  - fwd_x = wr_en_i & (wr_addr_i == rd_addr_x_i).
  - busy[0] and out-of-range addresses count as 0.
- A stall on either port blocks both ports. Both outputs hold, keeping the ports in lockstep.
- Both ports may read the same address in the same cycle; both return the identical value.

## Timing
- Read latency: 1 cycle. Address sampled at edge N, data valid on dout_x_o after edge N and stable until the next accepted read.
- Write latency: 1 cycle to storage, 0 cycles via forwarding. A read in the same cycle as a write to the same address returns the new data.
- busy_o reflects set/clear after the edge on which they are sampled.
- stall_o is combinational from rd_en/rd_addr/wr_en/wr_addr and the registered busy bits. It has no path from din_i.
- Reset (rst_n_i=0, asynchronous assert, synchronous deassert expected): all registers, dout_a_o, dout_b_o and busy_o go to 0 immediately.
  - Reset mid-operation discards any in-flight write, reservation and read.
  - Stall is deasserted because busy is cleared.

## Test plan
- Reset then read: reset, write 0xA5 to r3, read A=r3 next cycle -> dout_a_o=0xA5 one cycle after the read; all outputs 0 during reset.
- Zero register: write 0xFF to r0, then read r0 on both ports -> dout_a_o=dout_b_o=0x00; busy_set on r0 -> busy_o[0] stays 0 and no stall.
- Forwarding: write 0x3C to r5 while reading r5 on port B in the same cycle (old value 0x11) -> dout_b_o=0x3C after the edge.
- Scoreboard stall: set busy r2; next cycle read A=r2 -> stall_o=1 and both douts hold; write 0x77 to r2 with the read still asserted -> stall_o=0 that cycle, dout_a_o=0x77, busy_o[2]=0.
- Set and clear collide: busy r4 set, then same cycle busy_set r4 + write r4=0x09 -> busy_o[4]=1 and reg holds 0x09; a later read of r4 stalls until the next write.
- Async reset mid-stall: busy r6, read r6 stalled, assert rst_n_i between edges -> busy_o, douts and stall_o go to 0 without waiting for a clock edge.
